// File: rtl/stall_mem_resp_pkg.sv
// Purpose  : shared state encoding, latency bounds and counter width for stall_mem_resp.
// Latency  : n/a (types and constants only).
// Backpres.: n/a.
package stall_mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateT;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 8;
  // Holds LATENCY_MAX-1 plus up to 3 random extra cycles.
  localparam int CNT_BITS    = 4;

  // A request is serviceable only when it is exactly one of load/store
  // and the byte address is halfword aligned.
  function automatic logic isValidReq(input logic rd, input logic wr, input logic addr0);
    return (rd ^ wr) && !addr0;
  endfunction

endpackage

// File: rtl/stall_mem_resp_lfsr4.sv
// Purpose  : 4-bit Fibonacci LFSR (taps 4,3) that free-runs every non-reset cycle.
// Latency  : q changes one cycle after each clock edge; reset loads SEED.
// Backpres.: none; it never stops advancing.
// Ports    : clk, rst (sync, active-high), q (current 4-bit state).
module lfsr4 #(
  parameter logic [3:0] SEED = 4'hA
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SEED;
    end else begin
      q <= {q[2:0], q[3] ^ q[2]};
    end
  end

endmodule

// File: rtl/stall_mem_resp.sv
// Purpose  : multi-cycle 16-bit data memory that stalls the requesting pipeline stage.
// Latency  : Done LATENCY cycles after acceptance, plus 0..3 LFSR cycles when RAND_STALL=1.
// Backpres.: Stall high while busy; Rd/Wr/Addr/DataIn ignored until the cycle after Done.
// Ports    : clk, rst (sync, active-high); Rd/Wr/Addr/DataIn request side;
//            DataOut (load data, held until next response), Done (1-cycle pulse),
//            Stall (busy), Err (1-cycle pulse for a rejected request).
module stall_mem_resp
  import stall_mem_resp_pkg::*;
#(
  parameter int         ADDR_BITS  = 10,
  parameter int         LATENCY    = 2,
  parameter int         RAND_STALL = 0,
  parameter logic [3:0] LFSR_SEED  = 4'hA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        Err
);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : gBadLatency
    $error("stall_mem_resp: LATENCY must be in 1..8");
  end
  if (LFSR_SEED == 4'h0) begin : gBadSeed
    $error("stall_mem_resp: LFSR_SEED must be nonzero");
  end

  stateT                state;
  stateT                stateNxt;
  logic [CNT_BITS-1:0]  waitCnt;
  logic [CNT_BITS-1:0]  cntNxt;
  logic [CNT_BITS-1:0]  loadCnt;
  logic                 accept;
  logic                 reqOk;
  logic                 reqBad;

  // Latched request, captured at acceptance.
  logic                 opIsRd;
  logic [ADDR_BITS-1:0] opIdx;
  logic [15:0]          opDat;

  // Operation that completes on the edge entering RESP. With a zero loaded
  // count the request goes IDLE->RESP directly, before the latch is valid,
  // so the live inputs are used instead.
  logic                 respIsRd;
  logic [ADDR_BITS-1:0] respIdx;
  logic [15:0]          respDat;

  logic [15:0]          mem [0:(2**ADDR_BITS)-1];
  logic [3:0]           lfsrQ;
  logic                 unusedBits;

  lfsr4 #(.SEED(LFSR_SEED)) uLfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsrQ)
  );

  // Upper address bits alias by design; only two LFSR bits feed the stall.
  assign unusedBits = ^{Addr[15:ADDR_BITS+1], lfsrQ[3:2]};

  assign reqOk  = isValidReq(Rd, Wr, Addr[0]);
  assign reqBad = (Rd || Wr) && !reqOk;

  always_comb begin
    stateNxt = state;
    cntNxt   = waitCnt;
    accept   = 1'b0;
    respIsRd = opIsRd;
    respIdx  = opIdx;
    respDat  = opDat;
    loadCnt  = CNT_BITS'(LATENCY - 1);
    if (RAND_STALL != 0) begin
      loadCnt = loadCnt + CNT_BITS'(lfsrQ[1:0]);
    end
    case (state)
      IDLE: begin
        if (reqOk) begin
          accept   = 1'b1;
          cntNxt   = loadCnt;
          stateNxt = (loadCnt != '0) ? WAIT : RESP;
          respIsRd = Rd;
          respIdx  = Addr[ADDR_BITS:1];
          respDat  = DataIn;
        end
      end
      WAIT: begin
        cntNxt = waitCnt - CNT_BITS'(1);
        if (waitCnt <= CNT_BITS'(1)) begin
          stateNxt = RESP;
        end
      end
      RESP:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      waitCnt <= '0;
      DataOut <= '0;
      Err     <= 1'b0;
      opIsRd  <= 1'b0;
      opIdx   <= '0;
      opDat   <= '0;
    end else begin
      state   <= stateNxt;
      waitCnt <= cntNxt;
      Err     <= (state == IDLE) && reqBad;
      if (accept) begin
        opIsRd <= Rd;
        opIdx  <= Addr[ADDR_BITS:1];
        opDat  <= DataIn;
      end
      // A write response clears DataOut so stale load data is never reused.
      if (stateNxt == RESP) begin
        DataOut <= respIsRd ? mem[respIdx] : 16'h0000;
      end
    end
  end

  // Array is not reset; a reset on the commit edge drops the pending write.
  always_ff @(posedge clk) begin
    if (!rst && (stateNxt == RESP) && !respIsRd) begin
      mem[respIdx] <= respDat;
    end
  end

  assign Done  = (state == RESP);
  assign Stall = (state != IDLE);

endmodule

// File: tb/tb_stall_mem_resp.sv
module tb_stall_mem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        rd = 1'b0, wr = 1'b0;
  logic [15:0] addr = 16'h0, dataIn = 16'h0;
  logic [15:0] dataOut;
  logic        done, stall, err;

  logic        rdR = 1'b0, wrR = 1'b0;
  logic [15:0] addrR = 16'h0, dataInR = 16'h0;
  logic [15:0] dataOutR;
  logic        doneR, stallR, errR;

  int checks = 0;
  int errors = 0;
  int sinceRst = 0;

  // LFSR states from seed 4'hA, taps 4,3, one per cycle after reset.
  logic [3:0]  lfsrTab [15];
  logic [15:0] refMemR [1024];
  logic [15:0] addrList [8];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) sinceRst = 0;
    else     sinceRst = sinceRst + 1;
  end

  stall_mem_resp dut (
    .clk(clk), .rst(rst), .Rd(rd), .Wr(wr), .Addr(addr), .DataIn(dataIn),
    .DataOut(dataOut), .Done(done), .Stall(stall), .Err(err)
  );

  stall_mem_resp #(.RAND_STALL(1), .LFSR_SEED(4'hA)) dutR (
    .clk(clk), .rst(rst), .Rd(rdR), .Wr(wrR), .Addr(addrR), .DataIn(dataInR),
    .DataOut(dataOutR), .Done(doneR), .Stall(stallR), .Err(errR)
  );

  function automatic logic [9:0] wordIdx(input logic [15:0] a);
    return a[10:1];
  endfunction

  // Issue one request and wait (bounded) for Done; lat=-1 on timeout.
  task automatic doOp(input bit sel, input bit isRd, input logic [15:0] a,
                      input logic [15:0] d, output logic [15:0] got, output int lat);
    @(negedge clk);
    if (sel) begin rdR = isRd; wrR = !isRd; addrR = a; dataInR = d; end
    else     begin rd  = isRd; wr  = !isRd; addr  = a; dataIn  = d; end
    lat = -1;
    got = 16'hxxxx;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (sel) begin rdR = 1'b0; wrR = 1'b0; end
      else     begin rd  = 1'b0; wr  = 1'b0; end
      if ((sel ? doneR : done) === 1'b1) begin
        lat = i;
        got = sel ? dataOutR : dataOut;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({dataOut, done, stall, err} !== 19'd0) begin
      errors++; $display("FAIL reset_fixed got %h want 0", {dataOut, done, stall, err});
    end
    checks++;
    if ({dataOutR, doneR, stallR, errR} !== 19'd0) begin
      errors++; $display("FAIL reset_rand got %h want 0", {dataOutR, doneR, stallR, errR});
    end
    rst = 1'b0;
  endtask

  task automatic test_write_timing();
    @(negedge clk); wr = 1'b1; addr = 16'h0010; dataIn = 16'h1234;   // cycle N
    @(negedge clk); wr = 1'b0;                                         // N+1
    checks++;
    if ({stall, done, err} !== 3'b100) begin
      errors++; $display("FAIL wr_n1 stall/done/err got %b want 100", {stall, done, err});
    end
    @(negedge clk);                                                    // N+2
    checks++;
    if ({stall, done, err} !== 3'b110 || dataOut !== 16'h0) begin
      errors++; $display("FAIL wr_n2 stall/done/err %b data %h want 110 0000", {stall, done, err}, dataOut);
    end
    @(negedge clk);                                                    // N+3
    checks++;
    if ({stall, done} !== 2'b00) begin
      errors++; $display("FAIL wr_n3 stall/done got %b want 00", {stall, done});
    end
  endtask

  task automatic test_read_hold();
    @(negedge clk); rd = 1'b1; addr = 16'h0010;
    @(negedge clk); rd = 1'b0;
    checks++;
    if ({stall, done} !== 2'b10) begin
      errors++; $display("FAIL rd_n1 stall/done got %b want 10", {stall, done});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || dataOut !== 16'h1234) begin
      errors++; $display("FAIL rd_n2 done %b data %h want 1 1234", done, dataOut);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || stall !== 1'b0 || dataOut !== 16'h1234) begin
      errors++; $display("FAIL rd_n3 done %b stall %b data %h want 0 0 1234", done, stall, dataOut);
    end
  endtask

  task automatic test_err();
    logic [15:0] got;
    int lat;
    @(negedge clk); rd = 1'b1; addr = 16'h0011;
    @(negedge clk); rd = 1'b0;
    checks++;
    if ({err, stall, done} !== 3'b100) begin
      errors++; $display("FAIL err_misalign err/stall/done got %b want 100", {err, stall, done});
    end
    @(negedge clk);
    checks++;
    if ({err, stall, done} !== 3'b000) begin
      errors++; $display("FAIL err_pulse err/stall/done got %b want 000", {err, stall, done});
    end
    rd = 1'b1; wr = 1'b1; addr = 16'h0010; dataIn = 16'hFFFF;
    @(negedge clk); rd = 1'b0; wr = 1'b0;
    checks++;
    if ({err, stall, done} !== 3'b100) begin
      errors++; $display("FAIL err_rdwr err/stall/done got %b want 100", {err, stall, done});
    end
    doOp(1'b0, 1'b1, 16'h0010, 16'h0, got, lat);
    checks++;
    if (lat != 2 || got !== 16'h1234) begin
      errors++; $display("FAIL err_noaccess lat %0d data %h want 2 1234", lat, got);
    end
  endtask

  task automatic test_reset_abort();
    logic [15:0] got;
    int lat;
    doOp(1'b0, 1'b0, 16'h0020, 16'h0000, got, lat);
    doOp(1'b0, 1'b1, 16'h0010, 16'h0000, got, lat);
    @(negedge clk); wr = 1'b1; addr = 16'h0020; dataIn = 16'hBEEF;   // N
    @(negedge clk); wr = 1'b0;                                         // N+1
    checks++;
    if (stall !== 1'b1 || dataOut !== 16'h1234) begin
      errors++; $display("FAIL abort_pre stall %b data %h want 1 1234", stall, dataOut);
    end
    rst = 1'b1;
    @(negedge clk);                                                    // N+2
    checks++;
    if ({dataOut, done, stall, err} !== 19'd0) begin
      errors++; $display("FAIL abort_outputs got %h want 0", {dataOut, done, stall, err});
    end
    rst = 1'b0;
    doOp(1'b0, 1'b1, 16'h0020, 16'h0000, got, lat);
    checks++;
    if (lat != 2 || got !== 16'h0000) begin
      errors++; $display("FAIL abort_nocommit lat %0d data %h want 2 0000", lat, got);
    end
  endtask

  task automatic test_alias();
    logic [15:0] got, a, a2, d;
    int lat, latW;
    doOp(1'b0, 1'b0, 16'h0800, 16'h5A5A, got, lat);
    doOp(1'b0, 1'b1, 16'h0000, 16'h0000, got, lat);
    checks++;
    if (lat != 2 || got !== 16'h5A5A) begin
      errors++; $display("FAIL alias_0800 lat %0d data %h want 2 5a5a", lat, got);
    end
    for (int k = 0; k < 6; k++) begin
      a  = 16'($urandom) & 16'hFFFE;
      d  = 16'($urandom);
      a2 = a ^ (16'($urandom_range(1, 31)) << 11);
      doOp(1'b0, 1'b0, a, d, got, latW);
      doOp(1'b0, 1'b1, a2, 16'h0000, got, lat);
      checks++;
      if (latW != 2 || lat != 2 || got !== d) begin
        errors++; $display("FAIL alias_rand wr %h rd %h lat %0d/%0d data %h want 2/2 %h", a, a2, latW, lat, got, d);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got, a, d, expDat;
    int lat, expLat, pick;
    for (int k = 0; k < 8; k++) begin
      a = 16'($urandom) & 16'hFFFE;
      d = 16'($urandom);
      doOp(1'b1, 1'b0, a, d, got, lat);
      refMemR[wordIdx(a)] = d;
      addrList[k] = a;
      checks++;
      if (lat < 2 || lat > 5) begin
        errors++; $display("FAIL rand_preload lat %0d want 2..5", lat);
      end
    end
    @(negedge clk);
    pick = $urandom_range(0, 7);
    rdR = 1'b1; addrR = addrList[pick];
    for (int r = 0; r < 20; r++) begin
      checks++;
      if (stallR !== 1'b0) begin
        errors++; $display("FAIL b2b_idle read %0d stall %b want 0", r, stallR);
      end
      expLat = 2 + int'(lfsrTab[sinceRst % 15] & 4'h3);
      expDat = refMemR[wordIdx(addrR)];
      lat = -1;
      for (int i = 1; i <= 8; i++) begin
        @(negedge clk);
        if (i == 1) begin
          checks++;
          if (stallR !== 1'b1) begin
            errors++; $display("FAIL b2b_accept read %0d stall %b want 1", r, stallR);
          end
        end
        if (doneR === 1'b1) begin lat = i; break; end
      end
      checks++;
      if (lat != expLat || lat < 2 || lat > 5) begin
        errors++; $display("FAIL b2b_latency read %0d got %0d want %0d", r, lat, expLat);
      end
      checks++;
      if (dataOutR !== expDat) begin
        errors++; $display("FAIL b2b_data read %0d got %h want %h", r, dataOutR, expDat);
      end
      if (r < 19) begin
        pick = $urandom_range(0, 7);
        addrR = addrList[pick];
      end else begin
        rdR = 1'b0;
      end
      @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (stallR !== 1'b0 || doneR !== 1'b0) begin
      errors++; $display("FAIL b2b_quiet stall %b done %b want 0 0", stallR, doneR);
    end
  endtask

  initial begin
    lfsrTab[0]  = 4'hA; lfsrTab[1]  = 4'h5; lfsrTab[2]  = 4'hB; lfsrTab[3]  = 4'h7;
    lfsrTab[4]  = 4'hF; lfsrTab[5]  = 4'hE; lfsrTab[6]  = 4'hC; lfsrTab[7]  = 4'h8;
    lfsrTab[8]  = 4'h1; lfsrTab[9]  = 4'h2; lfsrTab[10] = 4'h4; lfsrTab[11] = 4'h9;
    lfsrTab[12] = 4'h3; lfsrTab[13] = 4'h6; lfsrTab[14] = 4'hD;
    test_reset();
    test_write_timing();
    test_read_hold();
    test_err();
    test_reset_abort();
    test_alias();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
